// File: rtl/ahb_lite_sdram_wbuf_if.sv
// rtl/ahb_lite_sdram_wbuf_if.sv - upstream AHB-Lite slave and downstream AHB-Lite master signal bundle.
// The slave modport is the write buffer's view; master is the view of whatever surrounds it.
interface ahb_lite_sdram_wbuf_if #(
  parameter int HADDR_BITS = 25
);
  logic                  HSEL;
  logic [HADDR_BITS-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic                  M_HSEL;
  logic [HADDR_BITS-1:0] M_HADDR;
  logic [1:0]            M_HTRANS;
  logic                  M_HWRITE;
  logic [2:0]            M_HSIZE;
  logic [31:0]           M_HWDATA;
  logic [31:0]           M_HRDATA;
  logic                  M_HREADY;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP,
    output M_HSEL, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA,
    input  M_HRDATA, M_HREADY
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP,
    input  M_HSEL, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HWDATA,
    output M_HRDATA, M_HREADY
  );
endinterface

// File: rtl/ahb_lite_sdram_wbuf.sv
// rtl/ahb_lite_sdram_wbuf.sv - AHB-Lite posted-write buffer in front of an SDRAM controller port.
// Define AHB_LITE_SDRAM_WBUF_FWD_EN to let reads hit queued word writes without a downstream access.
module ahb_lite_sdram_wbuf #(
  parameter int HADDR_BITS = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_sdram_wbuf_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {M_IDLE, M_WADDR, M_WDATA, M_RADDR, M_RDATA} mstate_e;

  mstate_e               state_q, state_d;
  logic [HADDR_BITS-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [HADDR_BITS-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [2:0]            fifo_size_q [FIFO_DEPTH];
  logic [2:0]            fifo_size_d [FIFO_DEPTH];
  logic [31:0]           fifo_data_q [FIFO_DEPTH];
  logic [31:0]           fifo_data_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic [HADDR_BITS-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [2:0]            wr_size_q, wr_size_d, rd_size_q, rd_size_d;
  logic [31:0]           hrdata_q, hrdata_d;
  logic [HADDR_BITS-1:0] m_haddr_q, m_haddr_d;
  logic                  m_hwrite_q, m_hwrite_d;
  logic [2:0]            m_hsize_q, m_hsize_d;
  logic [31:0]           m_hwdata_q, m_hwdata_d;
`ifdef AHB_LITE_SDRAM_WBUF_FWD_EN
  logic                  rd_new_q, rd_new_d, fwd_hit_q, fwd_hit_d;
  logic [31:0]           fwd_data_q, fwd_data_d;
  logic [PW-1:0]         scan_idx;
`endif
  logic                  full, pop, push, rd_done, rd_req, rd_fin, hready, accept, m_sel;
  logic [31:0]           rd_value;
  logic                  unused_ok;

  always_comb begin
    state_d     = state_q;
    fifo_addr_d = fifo_addr_q;
    fifo_size_d = fifo_size_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_pend_d   = wr_pend_q;
    rd_pend_d   = rd_pend_q;
    wr_addr_d   = wr_addr_q;
    wr_size_d   = wr_size_q;
    rd_addr_d   = rd_addr_q;
    rd_size_d   = rd_size_q;
    hrdata_d    = hrdata_q;
    m_haddr_d   = m_haddr_q;
    m_hwrite_d  = m_hwrite_q;
    m_hsize_d   = m_hsize_q;
    m_hwdata_d  = m_hwdata_q;
    m_sel       = 1'b0;
    rd_value    = bus.M_HRDATA;
    full        = (count_q == FULL_CNT);
    pop         = (state_q == M_WDATA) && bus.M_HREADY;
    rd_done     = (state_q == M_RDATA) && bus.M_HREADY;
`ifdef AHB_LITE_SDRAM_WBUF_FWD_EN
    rd_new_d    = 1'b0;
    fwd_hit_d   = fwd_hit_q;
    fwd_data_d  = fwd_data_q;
    scan_idx    = rd_ptr_q;
    // The first read data-phase cycle is spent searching the queue; only a miss goes downstream.
    rd_req      = rd_pend_q && !rd_new_q && !fwd_hit_q;
    rd_fin      = rd_pend_q && (rd_done || fwd_hit_q);
    if (fwd_hit_q) rd_value = fwd_data_q;
`else
    rd_req      = rd_pend_q;
    rd_fin      = rd_pend_q && rd_done;
`endif
    // A full queue can still take the write if the head leaves in the same cycle.
    hready = !(wr_pend_q && full && !pop) && !(rd_pend_q && !rd_fin);
    push   = wr_pend_q && hready;
    accept = bus.HSEL && bus.HTRANS[1] && hready;

    if (push) begin
      fifo_addr_d[wr_ptr_q] = wr_addr_q;
      fifo_size_d[wr_ptr_q] = wr_size_q;
      fifo_data_d[wr_ptr_q] = bus.HWDATA;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      wr_pend_d = 1'b0;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

    if (rd_fin) begin
      rd_pend_d = 1'b0;
      hrdata_d  = rd_value;
    end
    if (accept) begin
      if (bus.HWRITE) begin
        wr_pend_d = 1'b1;
        wr_addr_d = bus.HADDR;
        wr_size_d = bus.HSIZE;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = bus.HADDR;
        rd_size_d = bus.HSIZE;
      end
    end

`ifdef AHB_LITE_SDRAM_WBUF_FWD_EN
    if (accept && !bus.HWRITE) rd_new_d = 1'b1;
    if (rd_new_q) begin
      // Ascending scan from the head so the newest matching entry wins.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        scan_idx = rd_ptr_q + PW'(i);
        if (((PW+1)'(i) < count_q) && (fifo_size_q[scan_idx] == 3'b010) &&
            (fifo_addr_q[scan_idx][HADDR_BITS-1:2] == rd_addr_q[HADDR_BITS-1:2])) begin
          fwd_hit_d  = 1'b1;
          fwd_data_d = fifo_data_q[scan_idx];
        end
      end
    end
    if (rd_fin) fwd_hit_d = 1'b0;
`endif

    case (state_q)
      M_IDLE: begin
        if (count_q != '0) state_d = M_WADDR;
        else if (rd_req)   state_d = M_RADDR;
      end
      M_WADDR: begin
        m_sel      = 1'b1;
        m_haddr_d  = fifo_addr_q[rd_ptr_q];
        m_hwrite_d = 1'b1;
        m_hsize_d  = fifo_size_q[rd_ptr_q];
        if (bus.M_HREADY) state_d = M_WDATA;
      end
      M_WDATA: begin
        m_hwdata_d = fifo_data_q[rd_ptr_q];
        if (bus.M_HREADY) state_d = ((count_q > (PW+1)'(1)) || push) ? M_WADDR : M_IDLE;
      end
      M_RADDR: begin
        m_sel      = 1'b1;
        m_haddr_d  = rd_addr_q;
        m_hwrite_d = 1'b0;
        m_hsize_d  = rd_size_q;
        if (bus.M_HREADY) state_d = M_RDATA;
      end
      M_RDATA: begin
        if (bus.M_HREADY) state_d = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= M_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_size_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      hrdata_q   <= '0;
      m_haddr_q  <= '0;
      m_hwrite_q <= 1'b0;
      m_hsize_q  <= '0;
      m_hwdata_q <= '0;
`ifdef AHB_LITE_SDRAM_WBUF_FWD_EN
      rd_new_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_size_q <= fifo_size_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_pend_q   <= wr_pend_d;
      rd_pend_q   <= rd_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_size_q   <= wr_size_d;
      rd_addr_q   <= rd_addr_d;
      rd_size_q   <= rd_size_d;
      hrdata_q    <= hrdata_d;
      m_haddr_q   <= m_haddr_d;
      m_hwrite_q  <= m_hwrite_d;
      m_hsize_q   <= m_hsize_d;
      m_hwdata_q  <= m_hwdata_d;
`ifdef AHB_LITE_SDRAM_WBUF_FWD_EN
      rd_new_q    <= rd_new_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_data_q  <= fwd_data_d;
`endif
    end
  end

  assign bus.HREADY   = hready;
  assign bus.HRESP    = 1'b0;
  assign bus.HRDATA   = rd_fin ? rd_value : hrdata_q;
  assign bus.M_HSEL   = m_sel;
  assign bus.M_HTRANS = m_sel ? 2'b10 : 2'b00;
  assign bus.M_HADDR  = m_haddr_d;
  assign bus.M_HWRITE = m_hwrite_d;
  assign bus.M_HSIZE  = m_hsize_d;
  assign bus.M_HWDATA = m_hwdata_d;
  assign unused_ok    = bus.HTRANS[0];
endmodule

// File: tb/tb_ahb_lite_sdram_wbuf.sv
// tb/tb_ahb_lite_sdram_wbuf.sv - directed self-checking bench for ahb_lite_sdram_wbuf.
module tb_ahb_lite_sdram_wbuf;
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks   = 0;
  int   failures = 0;

  ahb_lite_sdram_wbuf_if #(.HADDR_BITS(AW)) bus ();
  ahb_lite_sdram_wbuf #(.HADDR_BITS(AW), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  // Downstream observer: logs each completed downstream transfer
  logic          dn_ph = 1'b0;
  logic [AW-1:0] dn_pa = '0;
  logic          dn_pw = 1'b0;
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  logic          log_wr[$];
  int            peak = 0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dn_ph <= 1'b0;
    end else begin
      if (int'(dut.count_q) > peak) peak <= int'(dut.count_q);
      if (bus.M_HREADY) begin
        if (dn_ph) begin
          log_addr.push_back(dn_pa);
          log_wr.push_back(dn_pw);
          log_data.push_back(dn_pw ? bus.M_HWDATA : bus.M_HRDATA);
        end
        dn_ph <= bus.M_HSEL && bus.M_HTRANS[1];
        dn_pa <= bus.M_HADDR;
        dn_pw <= bus.M_HWRITE;
      end
    end
  end

  logic [AW-1:0] wa[16];
  logic [31:0]   wd[16];

  task automatic upstream_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HADDR = '0; bus.HSIZE = 3'b010; bus.HWDATA = '0;
  endtask

  task automatic apply_reset();
    upstream_idle();
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    log_addr.delete(); log_data.delete(); log_wr.delete();
    peak = 0;
  endtask

  task automatic run_writes(input int n, output int stalls);
    int guard;
    stalls = 0;
    guard  = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1;
        bus.HADDR = wa[i]; bus.HSIZE = 3'b010;
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
      end
      if (i > 0) bus.HWDATA = wd[i-1];
      @(negedge HCLK);
      while (!bus.HREADY && guard < 200) begin
        stalls++; guard++;
        @(negedge HCLK);
      end
      @(posedge HCLK); #1;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL write_timeout: HREADY stayed %0b, required 1", bus.HREADY);
    end
  endtask

  task automatic run_read(input logic [AW-1:0] a, output logic [31:0] d, output int waits);
    int guard;
    waits = 0;
    guard = 0;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0;
    bus.HADDR = a; bus.HSIZE = 3'b010;
    @(negedge HCLK);
    while (!bus.HREADY && guard < 200) begin guard++; @(negedge HCLK); end
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    @(negedge HCLK);
    while (!bus.HREADY && guard < 200) begin
      waits++; guard++;
      @(negedge HCLK);
    end
    d = bus.HRDATA;
    @(posedge HCLK); #1;
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL read_timeout: HREADY stayed %0b, required 1", bus.HREADY);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge HCLK);
    checks++; if (bus.HREADY !== 1'b1)     begin failures++; $display("FAIL reset_hready: got %0b want 1", bus.HREADY); end
    checks++; if (bus.HRDATA !== 32'h0)    begin failures++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA); end
    checks++; if (bus.HRESP !== 1'b0)      begin failures++; $display("FAIL reset_hresp: got %0b want 0", bus.HRESP); end
    checks++; if (bus.M_HSEL !== 1'b0)     begin failures++; $display("FAIL reset_m_hsel: got %0b want 0", bus.M_HSEL); end
    checks++; if (bus.M_HTRANS !== 2'b00)  begin failures++; $display("FAIL reset_m_htrans: got %b want 00", bus.M_HTRANS); end
    checks++; if (bus.M_HWRITE !== 1'b0)   begin failures++; $display("FAIL reset_m_hwrite: got %0b want 0", bus.M_HWRITE); end
    checks++; if (bus.M_HADDR !== '0)      begin failures++; $display("FAIL reset_m_haddr: got %h want 0", bus.M_HADDR); end
    checks++; if (bus.M_HSIZE !== 3'b000)  begin failures++; $display("FAIL reset_m_hsize: got %b want 000", bus.M_HSIZE); end
    checks++; if (bus.M_HWDATA !== 32'h0)  begin failures++; $display("FAIL reset_m_hwdata: got %h want 0", bus.M_HWDATA); end
    checks++; if (dut.count_q !== '0)      begin failures++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_in_order_writes();
    int stalls;
    apply_reset();
    bus.M_HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wa[i] = AW'(32'h10 + 4 * i);
      wd[i] = 32'hA5A5_0000 + 32'(i);
    end
    run_writes(4, stalls);
    checks++; if (stalls !== 0) begin failures++; $display("FAIL inorder_stalls: got %0d want 0", stalls); end
    repeat (30) @(posedge HCLK);
    #1;
    checks++; if (log_addr.size() !== 4) begin failures++; $display("FAIL inorder_count: got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checks++; if (log_addr[i] !== wa[i]) begin failures++; $display("FAIL inorder_addr%0d: got %h want %h", i, log_addr[i], wa[i]); end
      checks++; if (log_data[i] !== wd[i]) begin failures++; $display("FAIL inorder_data%0d: got %h want %h", i, log_data[i], wd[i]); end
      checks++; if (log_wr[i] !== 1'b1)    begin failures++; $display("FAIL inorder_write%0d: got %0b want 1", i, log_wr[i]); end
    end
  endtask

  task automatic test_full_stall();
    int   stalls;
    logic bad;
    apply_reset();
    bus.M_HREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wa[i] = AW'(32'h100 + 4 * i);
      wd[i] = 32'h5000_0000 + 32'(i * 3);
    end
    run_writes(4, stalls);
    checks++; if (stalls !== 0) begin failures++; $display("FAIL full_first4_stalls: got %0d want 0", stalls); end
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL full_count4: got %0d want 4", dut.count_q); end
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = wa[4]; bus.HSIZE = 3'b010;
    @(negedge HCLK);
    checks++; if (bus.HREADY !== 1'b1) begin failures++; $display("FAIL full_addr_phase: HREADY got %0b want 1", bus.HREADY); end
    @(posedge HCLK); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wd[4];
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      if (bus.HREADY !== 1'b0) bad = 1'b1;
      @(posedge HCLK); #1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL full_hold: HREADY rose while full, got 1 want 0"); end
    bus.M_HREADY = 1'b1;
    @(negedge HCLK);
    checks++; if (bus.HREADY !== 1'b0) begin failures++; $display("FAIL full_before_pop: HREADY got %0b want 0", bus.HREADY); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++; if (bus.HREADY !== 1'b1) begin failures++; $display("FAIL full_on_pop: HREADY got %0b want 1", bus.HREADY); end
    @(posedge HCLK); #1;
    checks++; if (dut.count_q !== 3'd4) begin failures++; $display("FAIL full_push_pop_count: got %0d want 4", dut.count_q); end
    repeat (30) @(posedge HCLK);
    #1;
    checks++; if (log_addr.size() !== 5) begin failures++; $display("FAIL full_dn_count: got %0d want 5", log_addr.size()); end
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== wa[i] || log_data[i] !== wd[i] || log_wr[i] !== 1'b1) begin
        failures++;
        $display("FAIL full_dn%0d: got %h/%h/%0b want %h/%h/1", i, log_addr[i], log_data[i], log_wr[i], wa[i], wd[i]);
      end
    end
  endtask

`ifndef AHB_LITE_SDRAM_WBUF_FWD_EN
  task automatic test_read_after_write();
    int          stalls, waits;
    logic [31:0] rdata;
    apply_reset();
    bus.M_HREADY = 1'b1;
    bus.M_HRDATA = 32'h5A5A_1234;
    wa[0] = AW'(32'h40); wd[0] = 32'hDEAD_BEEF;
    run_writes(1, stalls);
    run_read(AW'(32'h40), rdata, waits);
    repeat (10) @(posedge HCLK);
    #1;
    checks++; if (rdata !== 32'h5A5A_1234) begin failures++; $display("FAIL raw_rdata: got %h want 5a5a1234", rdata); end
    checks++; if (waits < 1) begin failures++; $display("FAIL raw_waits: got %0d want >=1", waits); end
    checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL raw_dn_count: got %0d want 2", log_addr.size()); end
    if (log_addr.size() == 2) begin
      checks++;
      if (log_wr[0] !== 1'b1 || log_addr[0] !== AW'(32'h40) || log_data[0] !== 32'hDEAD_BEEF) begin
        failures++; $display("FAIL raw_first_write: got %0b/%h/%h want 1/40/deadbeef", log_wr[0], log_addr[0], log_data[0]);
      end
      checks++;
      if (log_wr[1] !== 1'b0 || log_addr[1] !== AW'(32'h40) || log_data[1] !== 32'h5A5A_1234) begin
        failures++; $display("FAIL raw_then_read: got %0b/%h/%h want 0/40/5a5a1234", log_wr[1], log_addr[1], log_data[1]);
      end
    end
  endtask
`else
  task automatic test_forward();
    int          stalls, waits;
    logic [31:0] rdata;
    apply_reset();
    bus.M_HREADY = 1'b0;
    bus.M_HRDATA = 32'h1111_2222;
    wa[0] = AW'(32'h80); wd[0] = 32'hCAFE_F00D;
    run_writes(1, stalls);
    run_read(AW'(32'h80), rdata, waits);
    checks++; if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL fwd_rdata: got %h want cafef00d", rdata); end
    checks++; if (waits !== 1) begin failures++; $display("FAIL fwd_waits: got %0d want 1", waits); end
    bus.M_HREADY = 1'b1;
    repeat (10) @(posedge HCLK);
    #1;
    checks++; if (log_addr.size() !== 1) begin failures++; $display("FAIL fwd_dn_count: got %0d want 1", log_addr.size()); end
    if (log_addr.size() == 1) begin
      checks++; if (log_wr[0] !== 1'b1) begin failures++; $display("FAIL fwd_no_read: got write=%0b want 1", log_wr[0]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int stalls;
    apply_reset();
    bus.M_HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wa[i] = AW'(32'h300 + 4 * i);
      wd[i] = 32'h7700_0000 + 32'(i);
    end
    run_writes(3, stalls);
    checks++; if (dut.count_q !== 3'd3) begin failures++; $display("FAIL rstmid_count_before: got %0d want 3", dut.count_q); end
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    checks++; if (dut.count_q !== '0) begin failures++; $display("FAIL rstmid_count: got %0d want 0", dut.count_q); end
    checks++; if (bus.M_HTRANS !== 2'b00) begin failures++; $display("FAIL rstmid_htrans: got %b want 00", bus.M_HTRANS); end
    bus.M_HREADY = 1'b1;
    repeat (10) @(posedge HCLK);
    #1;
    checks++; if (log_addr.size() !== 0) begin failures++; $display("FAIL rstmid_dn_count: got %0d want 0", log_addr.size()); end
    checks++; if (bus.M_HTRANS !== 2'b00) begin failures++; $display("FAIL rstmid_htrans_later: got %b want 00", bus.M_HTRANS); end
  endtask

  task automatic test_back_to_back_wrap();
    int stalls;
    apply_reset();
    bus.M_HREADY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wa[i] = AW'(32'h200 + 4 * i);
      wd[i] = 32'h1000_0000 + 32'(i * 32'h111);
    end
    fork
      run_writes(10, stalls);
      begin
        repeat (8) @(posedge HCLK);
        #1 bus.M_HREADY = 1'b1;
      end
    join
    repeat (40) @(posedge HCLK);
    #1;
    checks++; if (stalls < 1) begin failures++; $display("FAIL wrap_stalls: got %0d want >=1", stalls); end
    checks++; if (peak !== DEPTH) begin failures++; $display("FAIL wrap_peak: got %0d want %0d", peak, DEPTH); end
    checks++; if (log_addr.size() !== 10) begin failures++; $display("FAIL wrap_dn_count: got %0d want 10", log_addr.size()); end
    for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== wa[i] || log_data[i] !== wd[i] || log_wr[i] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_dn%0d: got %h/%h/%0b want %h/%h/1", i, log_addr[i], log_data[i], log_wr[i], wa[i], wd[i]);
      end
    end
    checks++; if (dut.wr_ptr_q !== 2'd2) begin failures++; $display("FAIL wrap_wr_ptr: got %0d want 2", dut.wr_ptr_q); end
    checks++; if (dut.rd_ptr_q !== 2'd2) begin failures++; $display("FAIL wrap_rd_ptr: got %0d want 2", dut.rd_ptr_q); end
    checks++; if (dut.count_q !== '0)    begin failures++; $display("FAIL wrap_count: got %0d want 0", dut.count_q); end
  endtask

  initial begin
    HRESET       = 1'b1;
    bus.M_HREADY = 1'b1;
    bus.M_HRDATA = 32'h0;
    upstream_idle();
    test_reset();
    test_in_order_writes();
    test_full_stall();
`ifndef AHB_LITE_SDRAM_WBUF_FWD_EN
    test_read_after_write();
`else
    test_forward();
`endif
    test_reset_mid();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_lite_sdram_wbuf.md
AHB_LITE_SDRAM_WBUF -- requirements
Module: ahb_lite_sdram_wbuf

Interface
REQ-001 SHALL have parameter HADDR_BITS, default 25, meaning the byte-address width on both ports.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of posted-write entries; legal values are 2, 4 and 8.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port HRESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have upstream AHB-Lite slave ports: HSEL in 1, HADDR in HADDR_BITS, HTRANS in 2, HWRITE in 1, HSIZE in 3, HWDATA in 32, HRDATA out 32, HREADY out 1, HRESP out 1.
REQ-006 SHALL have downstream AHB-Lite master ports: M_HSEL out 1, M_HADDR out HADDR_BITS, M_HTRANS out 2, M_HWRITE out 1, M_HSIZE out 3, M_HWDATA out 32, M_HRDATA in 32, M_HREADY in 1.
REQ-007 SHALL drive HRESP constant 0 (OKAY).

Function
REQ-008 Upstream address phase accepted when HSEL=1, HTRANS[1]=1 and HREADY=1; IDLE and BUSY transfers are ignored.
REQ-009 Accepted write: HADDR and HSIZE latched at the address phase; HWDATA latched at the data phase; the {addr,size,data} entry is pushed at the end of the data phase.
REQ-010 Write data phase: HREADY=1 when FIFO count < FIFO_DEPTH; otherwise HREADY=0 until a pop frees a slot (zero-wait posted write when not full).
REQ-011 Pop and push in the same cycle with FIFO full SHALL both succeed; count is unchanged.
REQ-012 Accepted read: HREADY=0 through the data phase until the FIFO is empty and the downstream read completes; HRDATA = M_HRDATA captured on the completing cycle, with HREADY=1 in that same cycle.
REQ-013 Downstream FSM states: M_IDLE, M_WADDR, M_WDATA, M_RADDR, M_RDATA.
REQ-014 M_IDLE -> M_WADDR when FIFO non-empty; M_IDLE -> M_RADDR when a read is pending and the FIFO is empty; writes always take priority over a pending read.
REQ-015 M_WADDR and M_RADDR drive M_HSEL=1, M_HTRANS=NONSEQ (2'b10) and the head/read address; they advance only when M_HREADY=1.
REQ-016 M_WDATA drives M_HWDATA from the FIFO head and pops on M_HREADY=1, then goes to M_WADDR if more entries are queued, else M_IDLE. M_RDATA waits for M_HREADY=1, then returns to M_IDLE.
REQ-017 Outside address phases: M_HTRANS=IDLE (2'b00) and M_HSEL=0; M_HADDR, M_HWRITE and M_HSIZE hold their last value.
REQ-018 Read-after-write ordering SHALL be preserved: no read issues downstream while any older write is queued.
REQ-019 FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-020 While HRESET=1 on a clock edge: FIFO emptied, count=0, FSM=M_IDLE, pending read cleared, HREADY=1, HRDATA=0, M_HSEL=0, M_HTRANS=2'b00, M_HWRITE=0, M_HADDR=0, M_HSIZE=0, M_HWDATA=0.
REQ-021 Reset asserted mid-transfer SHALL discard queued writes and any in-flight transfer, with no further downstream activity until new requests arrive.

Configuration
REQ-022 Macro AHB_LITE_SDRAM_WBUF_FWD_EN defined: a read whose word address (HADDR[HADDR_BITS-1:2]) matches a queued word-size (HSIZE=3'b010) entry completes with the newest matching entry's data, one cycle after the address phase, with no downstream access.
REQ-023 Macro undefined: no forwarding is done and every read follows REQ-012 and REQ-018.

Verification
REQ-024 Four writes to 0x10,0x14,0x18,0x1C with M_HREADY=1 -> HREADY stays 1; downstream writes occur in order with the same addresses and data.
REQ-025 Five back-to-back writes with M_HREADY held 0 and FIFO_DEPTH=4 -> the 5th data phase holds HREADY=0 until M_HREADY=1 pops an entry.
REQ-026 Write 0xDEADBEEF to 0x40, then read 0x40 (no FWD macro) -> the downstream write precedes the read; HRDATA equals the M_HRDATA returned for the read.
REQ-027 With FWD macro: write 0xCAFEF00D to 0x80, then read 0x80 while M_HREADY=0 -> HRDATA=0xCAFEF00D after one wait cycle; no downstream read is issued.
REQ-028 Three writes queued, assert HRESET for one cycle -> count=0, M_HTRANS=2'b00, and no further downstream writes occur.
REQ-029 FIFO full, with a simultaneous push and pop -> count stays FIFO_DEPTH and the pointers wrap correctly across 10 writes.
